des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
Iterative DES encrypt/decrypt core for the IOT data-filtering datapath. It consumes the eight 6-in/4-out S-box lookup blocks S1..S8 (row = {b5,b0}, column = b4:b1) and wraps them in a Feistel round, key schedule and control. One 64-bit block is processed per request, one round per clock, 16 rounds, with valid/ready handshakes on input and output. All permutations and tables (IP, FP, E, P, PC-1, PC-2, shift schedule) follow FIPS 46-3 exactly; bit 1 of FIPS is the MSB of each bus.

Parameters:
ROUNDS, 16, number of Feistel rounds; fixed for DES and not meant to be overridden.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  engine can accept a request
mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept
key  input  64  DES key including parity bits; sampled on accept
din  input  64  plaintext or ciphertext block; sampled on accept
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
dout  output  64  result block
busy  output  1  high while in ROUND or DONE
key_err  output  1  only present when DES_KEY_PARITY_EN is defined

Behaviour:
- Reset (rst high at a clk edge) forces: state = IDLE, in_ready = 1, out_valid = 0, dout = 0, busy = 0, key_err = 0, round counter = 0.
- Reset wins over every other event, including a mid-round reset.
- State IDLE:
  - in_ready = 1.
  - Accept on an edge with in_valid & in_ready.
  - On accept: {L0,R0} = IP(din); {C,D} = PC-1(key); mode latched; cnt = 0; go to ROUND.
- State ROUND:
  - in_ready = 0.
  - Each edge computes one round: R' = L ^ P(S(E(R) ^ Kcnt)); L' = R; cnt increments.
  - S() applies S1..S8 to the 48-bit word in 6-bit slices, MSB slice to S1.
- Subkeys:
  - Encrypt: C and D are rotated left by the FIPS shift for round cnt+1 (1 for rounds 1, 2, 9, 16; otherwise 2) before PC-2.
  - Decrypt: round 1 uses PC-2 of the unrotated C/D. Later rounds rotate right by the FIPS shift of encrypt round 18-(cnt+1) (1 for decrypt rounds 2, 9, 16; otherwise 2). This reproduces K16..K1.
  - Rotations are 28-bit wrap-around.
- After the edge where cnt = 15: dout = FP(R16 || L16) (swap applied), out_valid = 1, go to DONE.
  - out_valid therefore rises exactly 16 edges after the accept edge.
- State DONE:
  - dout and out_valid are held stable while out_ready = 0.
  - On an edge with out_ready = 1: out_valid = 0, go to IDLE. in_ready = 1 from the next cycle.
  - A new request cannot be accepted in the same cycle as output retirement; throughput is 1 block per 18 cycles minimum.
- Input changes while not in IDLE are ignored.
- dout keeps its last value after retirement and is only meaningful while out_valid = 1.

Optional Feature:
Macro DES_KEY_PARITY_EN.
- Defined:
  - Each key byte is checked for odd parity on accept, and the result is latched.
  - If any byte has even parity, the engine still runs 16 cycles, but it presents dout = 0 and key_err = 1 together with out_valid.
  - key_err clears when the result is retired or on reset.
- Not defined:
  - Parity bits are ignored and the key_err port does not exist.
  - Behaviour is otherwise identical.

Test Plan:
- Encrypt, key 133457799BBCDFF1, din 0123456789ABCDEF, out_ready = 1 -> out_valid exactly 16 cycles after accept, dout = 85E813540F0AB405.
- Decrypt, same key, din 85E813540F0AB405 -> dout = 0123456789ABCDEF. Encrypt, key 0E329232EA6D0D73, din 8787878787878787 -> dout = 0000000000000000.
- Back-pressure: out_ready held 0 for 5 cycles after out_valid -> dout stable at 85E813540F0AB405, in_ready = 0 and busy = 1 throughout; retire, then a back-to-back second request is accepted 1 cycle later.
- Reset mid-operation: assert rst at round 7 for 1 cycle -> next cycle out_valid = 0, in_ready = 1, busy = 0. A new request then produces the correct result with no residue from the aborted block.
- in_valid held high during ROUND with a changing din -> ignored; result matches the originally accepted block.
- DES_KEY_PARITY_EN defined, key 123457799BBCDFF1 (byte 12 has even parity) -> out_valid after 16 cycles with key_err = 1 and dout = 0. Key 133457799BBCDFF1 -> key_err = 0 and the normal ciphertext.

Source files
------------

// File: rtl/des_round_engine.sv
// Iterative DES core: one Feistel round per clock, 16 rounds, valid/ready on both sides.
// Define DES_KEY_PARITY_EN to add per-byte odd-parity checking of the key and the key_err port.

module des_sbox #(
  parameter int IDX = 0
) (
  input  logic [5:0] x,
  output logic [3:0] y
);
  // S1..S8, row-major (row*16+col), entry 0 in the top nibble
  localparam logic [2047:0] ALL = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
  localparam logic [255:0] TBL = ALL[(7-IDX)*256 +: 256];

  logic [5:0] idx;
  assign idx = {x[5], x[0], x[4:1]};
  assign y   = TBL[{~idx, 2'b00} +: 4];
endmodule

module des_round_engine #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] key,
  input  logic [63:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout,
`ifdef DES_KEY_PARITY_EN
  output logic        key_err,
`endif
  output logic        busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        dec;
  logic [31:0] l, r, rn, s_w, f_w;
  logic [27:0] c, d;
  logic [55:0] pc1_w, cd_n;
  logic [47:0] e_w, k_w, x_w;
  logic [63:0] ip_w, fp_w, pre_fp;
  logic [1:0]  sh;
  logic        one_sh, last;

  function automatic logic [27:0] rot(input logic [27:0] v, input logic [1:0] n, input logic right);
    case ({right, n})
      3'b001:  rot = {v[26:0], v[27]};
      3'b010:  rot = {v[25:0], v[27:26]};
      3'b101:  rot = {v[0], v[27:1]};
      3'b110:  rot = {v[1:0], v[27:2]};
      default: rot = v;
    endcase
  endfunction

  // Decrypt walks the schedule backwards: no shift on round 1, then right rotations
  assign one_sh = (cnt == 4'd1) || (cnt == 4'd8) || (cnt == 4'd15) || (!dec && cnt == 4'd0);
  assign sh     = (dec && cnt == 4'd0) ? 2'd0 : (one_sh ? 2'd1 : 2'd2);
  assign cd_n   = {rot(c, sh, dec), rot(d, sh, dec)};
  assign x_w    = e_w ^ k_w;
  assign rn     = l ^ f_w;
  assign pre_fp = {rn, r};
  assign last   = (cnt == 4'(ROUNDS - 1));

  for (genvar i = 0; i < 64; i++) begin : g_ip_fp
    assign ip_w[63-i] = din[64-IP_T[i]];
    assign fp_w[63-i] = pre_fp[64-FP_T[i]];
  end
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_w[55-i] = key[64-PC1_T[i]];
  end
  for (genvar i = 0; i < 48; i++) begin : g_e_pc2
    assign e_w[47-i] = r[32-E_T[i]];
    assign k_w[47-i] = cd_n[56-PC2_T[i]];
  end
  for (genvar i = 0; i < 8; i++) begin : g_sbox
    des_sbox #(.IDX(i)) u_sbox (.x(x_w[47-6*i -: 6]), .y(s_w[31-4*i -: 4]));
  end
  for (genvar i = 0; i < 32; i++) begin : g_p
    assign f_w[31-i] = s_w[32-P_T[i]];
  end

`ifdef DES_KEY_PARITY_EN
  logic       par_bad;
  logic [7:0] byte_odd;
  for (genvar i = 0; i < 8; i++) begin : g_par
    assign byte_odd[i] = ^key[8*i +: 8];
  end
`else
  logic unused_par;
  assign unused_par = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
`endif

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      dec       <= 1'b0;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
`ifdef DES_KEY_PARITY_EN
      par_bad   <= 1'b0;
      key_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          {l, r}  <= ip_w;
          {c, d}  <= pc1_w;
          dec     <= mode;
          cnt     <= 4'd0;
`ifdef DES_KEY_PARITY_EN
          par_bad <= ~&byte_odd;
`endif
          state   <= S_ROUND;
        end
        S_ROUND: begin
          l      <= r;
          r      <= rn;
          {c, d} <= cd_n;
          cnt    <= cnt + 4'd1;
          if (last) begin
`ifdef DES_KEY_PARITY_EN
            dout    <= par_bad ? 64'd0 : fp_w;
            key_err <= par_bad;
`else
            dout    <= fp_w;
`endif
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
`ifdef DES_KEY_PARITY_EN
          key_err   <= 1'b0;
`endif
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: FIPS vector table, hand sequences, random blocks vs. a DES model.
// Honours DES_KEY_PARITY_EN the same way as the design.

module tb_des_round_engine;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [63:0] key = '0, din = '0, dout;
`ifdef DES_KEY_PARITY_EN
  logic        key_err;
`endif
  int total = 0, bad = 0;

  des_round_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .key(key), .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
`ifdef DES_KEY_PARITY_EN
    .key_err(key_err),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Permutations: output bit i (MSB first) takes input bit t[i] counted from the MSB of an iw-bit word
  function automatic logic [63:0] perm64(input logic [63:0] x, input int iw, input int t [64]);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = (y << 1) | ((x >> (iw - t[i])) & 64'd1);
    return y;
  endfunction
  function automatic logic [63:0] perm56(input logic [63:0] x, input int iw, input int t [56]);
    logic [63:0] y = '0;
    for (int i = 0; i < 56; i++) y = (y << 1) | ((x >> (iw - t[i])) & 64'd1);
    return y;
  endfunction
  function automatic logic [63:0] perm48(input logic [63:0] x, input int iw, input int t [48]);
    logic [63:0] y = '0;
    for (int i = 0; i < 48; i++) y = (y << 1) | ((x >> (iw - t[i])) & 64'd1);
    return y;
  endfunction
  function automatic logic [63:0] perm32(input logic [63:0] x, input int iw, input int t [32]);
    logic [63:0] y = '0;
    for (int i = 0; i < 32; i++) y = (y << 1) | ((x >> (iw - t[i])) & 64'd1);
    return y;
  endfunction

  // Textbook DES: precompute K1..K16 with cumulative left shifts, decrypt uses them reversed
  function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] b, input logic dec);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] x;
    logic [31:0] l, r, s, nl;
    int six;
    t = perm56(k, 64, PC1_T);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < SHIFTS[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm48({8'd0, c, d}, 56, PC2_T);
      ks[i] = t[47:0];
    end
    t = perm64(b, 64, IP_T);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      t = perm48({32'd0, r}, 32, E_T);
      x = t[47:0] ^ ks[dec ? 15 - i : i];
      s = '0;
      for (int j = 0; j < 8; j++) begin
        six = int'(x >> (42 - 6 * j)) & 63;
        s = (s << 4) | 32'(SB[j][(((six >> 4) & 2) | (six & 1)) * 16 + ((six >> 1) & 15)]);
      end
      t = perm32({32'd0, s}, 32, P_T);
      nl = r;
      r = l ^ t[31:0];
      l = nl;
    end
    return perm64({r, l}, 64, FP_T);
  endfunction

  function automatic logic [63:0] fixpar(input logic [63:0] k);
    for (int i = 0; i < 8; i++) k[8*i] = ~^k[8*i+1 +: 7];
    return k;
  endfunction

`ifdef DES_KEY_PARITY_EN
  function automatic logic even_byte(input logic [63:0] k);
    logic e = 1'b0;
    for (int i = 0; i < 8; i++) if (!(^k[8*i +: 8])) e = 1'b1;
    return e;
  endfunction
`endif

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  // One block: accept, count edges to out_valid, hold for `hold` cycles, retire
  task automatic xact(input string nm, input logic m, input logic [63:0] k, input logic [63:0] b,
                      input logic [63:0] exp, input int hold, input logic noise);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk1({nm, " ready"}, in_ready, 1'b1);
    in_valid = 1'b1; mode = m; key = k; din = b;
    out_ready = (hold == 0);
    @(negedge clk);
    chk1({nm, " accept"}, in_ready, 1'b0);
    in_valid = noise;
    n = 0;
    while (!out_valid && n < 40) begin
      if (noise) begin
        din = {$urandom, $urandom};
        key = {$urandom, $urandom};
        mode = ~mode;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, 64'(n), 64'd16);
    chk({nm, " dout"}, dout, exp);
`ifdef DES_KEY_PARITY_EN
    chk1({nm, " key_err"}, key_err, even_byte(k));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold dout"}, dout, exp);
      chk1({nm, " hold valid"}, out_valid, 1'b1);
      chk1({nm, " hold in_ready"}, in_ready, 1'b0);
      chk1({nm, " hold busy"}, busy, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1({nm, " retire valid"}, out_valid, 1'b0);
    chk1({nm, " retire in_ready"}, in_ready, 1'b1);
`ifdef DES_KEY_PARITY_EN
    chk1({nm, " retire key_err"}, key_err, 1'b0);
`endif
  endtask

  typedef struct {
    logic        m;
    logic [63:0] k;
    logic [63:0] d;
    logic [63:0] e;
    int          hold;
    logic        noise;
  } vec_t;

  vec_t        vt [8];
  logic        rm;
  logic [63:0] rk, rb, rc;

  initial begin
    vt[0] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0};
    vt[1] = '{1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0};
    vt[2] = '{1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000, 0, 1'b0};
    vt[3] = '{1'b1, 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 1, 1'b0};
    vt[4] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 5, 1'b0};
    vt[5] = '{1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0};
    vt[6] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 2, 1'b1};
`ifdef DES_KEY_PARITY_EN
    vt[7] = '{1'b0, 64'h123457799BBCDFF1, 64'h0123456789ABCDEF, 64'h0000000000000000, 0, 1'b0};
`else
    vt[7] = '{1'b0, 64'h123457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0};
`endif

    repeat (2) @(negedge clk);
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk("reset dout", dout, 64'd0);
`ifdef DES_KEY_PARITY_EN
    chk1("reset key_err", key_err, 1'b0);
`endif
    rst = 1'b0;

    // Rows 4 -> 5 run back to back: row 5 is accepted on the first edge after retirement
    for (int i = 0; i < 8; i++)
      xact($sformatf("vec%0d", i), vt[i].m, vt[i].k, vt[i].d, vt[i].e, vt[i].hold, vt[i].noise);

    // Abort a block part-way through the rounds
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b0; key = 64'h0E329232EA6D0D73; din = 64'h8787878787878787;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk1("midrst busy before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst out_valid", out_valid, 1'b0);
    chk1("midrst in_ready", in_ready, 1'b1);
    chk1("midrst busy", busy, 1'b0);
    chk("midrst dout", dout, 64'd0);
    xact("after midrst", 1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rm = 1'($urandom_range(0, 1));
      rk = fixpar({$urandom, $urandom});
      rb = {$urandom, $urandom};
      rc = des_ref(rk, rb, rm);
      xact($sformatf("rand%0d", i), rm, rk, rb, rc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      xact($sformatf("inv%0d", i), ~rm, rk, rc, rb, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
